// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the elastic pipeline stage registers.
//   - pipe_state_t : occupancy state of a stage register
//                    (EMPTY = nothing held, BUSY = main register full,
//                     FULL = main and skid registers both full)
//   - per-boundary control/payload widths and bubble control values
//     for the IF/ID, ID/EX, EX/MEM and MEM/WB instances.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // Control bundle widths per stage boundary
  localparam int IF_ID_CTRL_W  = 10;
  localparam int ID_EX_CTRL_W  = 10;
  localparam int EX_MEM_CTRL_W = 10;
  localparam int MEM_WB_CTRL_W = 10;

  // Payload widths per stage boundary
  localparam int IF_ID_DATA_W  = 123;
  localparam int ID_EX_DATA_W  = 123;
  localparam int EX_MEM_DATA_W = 123;
  localparam int MEM_WB_DATA_W = 123;

  // Bubble control values: all-zero control means no regfile write and
  // no memory write, so a bubble is architecturally inert.
  localparam logic [IF_ID_CTRL_W-1:0]  IF_ID_CTRL_BUBBLE  = '0;
  localparam logic [ID_EX_CTRL_W-1:0]  ID_EX_CTRL_BUBBLE  = '0;
  localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_CTRL_BUBBLE = '0;
  localparam logic [MEM_WB_CTRL_W-1:0] MEM_WB_CTRL_BUBBLE = '0;

  // Default counter width for the performance counters
  localparam int PIPE_CNT_W = 16;

endpackage

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt
// Saturating up-counter used by the pipeline performance counters.
// The count stops at all-ones instead of wrapping.
// Ports:
//   clk   : clock, counts on rising edge
//   rst   : asynchronous active-high reset, clears the count
//   en    : count enable
//   count : current count value (CNT_W bits)
module pipe_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Increment while enabled, but freeze once every bit is set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Elastic pipeline register between two processor stages. Carries a
// control bundle and a payload with a valid/ready handshake, honours
// downstream back-pressure, supports a synchronous flush that turns the
// stage into a bubble, and counts back-pressured cycles.
//
// Build option (macro PIPE_SKID_EN):
//   defined   : main + skid register, in_ready is a flop output so no
//               combinational ready path runs from out_ready to in_ready.
//   undefined : main register only, in_ready = !out_valid | out_ready.
//
// Ports:
//   clk       : clock
//   rst       : asynchronous active-high reset
//   flush     : synchronous kill of stage contents
//   in_valid  : upstream item valid
//   in_ready  : stage can accept an item
//   in_ctrl   : upstream control bundle (CTRL_W)
//   in_data   : upstream payload (DATA_W)
//   out_valid : out_ctrl/out_data hold a valid item
//   out_ready : downstream accepts this cycle
//   out_ctrl  : registered control, CTRL_BUBBLE while out_valid=0
//   out_data  : registered payload, holds last value while out_valid=0
//   stall_cnt : saturating count of cycles with out_valid & !out_ready
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 CTRL_W      = 10,
  parameter int                 DATA_W      = 123,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state;
  pipe_state_t       state_nxt;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] ctrl_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              in_xfer;
  logic              load_main_in;

  assign in_xfer  = in_valid & in_ready;
  assign out_ctrl = main_ctrl;
  assign out_data = main_data;

`ifdef PIPE_SKID_EN

  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              load_main_skid;
  logic              load_skid;

  // Next-state logic for the two-entry stage. Flush wins over every
  // other event; the skid entry only ever refills the main register.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            state_nxt    = BUSY;
            load_main_in = 1'b1;
          end
        end
        BUSY: begin
          if (in_xfer && out_ready) begin
            load_main_in = 1'b1;
          end else if (in_xfer) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (out_ready) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            state_nxt      = BUSY;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Main register source selection: fresh input, or the parked skid item
  always_comb begin
    data_nxt = main_data;
    if (load_main_in) begin
      data_nxt = in_data;
    end else if (load_main_skid) begin
      data_nxt = skid_data;
    end
  end

  // Control follows the same selection, but an empty stage shows a bubble
  always_comb begin
    ctrl_nxt = main_ctrl;
    if (state_nxt == EMPTY) begin
      ctrl_nxt = CTRL_BUBBLE;
    end else if (load_main_in) begin
      ctrl_nxt = in_ctrl;
    end else if (load_main_skid) begin
      ctrl_nxt = skid_ctrl;
    end
  end

  // Skid register and registered ready; ready is precomputed from the
  // next state so it never depends combinationally on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_ctrl <= '0;
      skid_data <= '0;
      in_ready  <= 1'b1;
    end else begin
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
      in_ready <= (state_nxt != FULL);
    end
  end

`else

  // Single-entry stage: accept whenever the held item leaves this cycle
  // or there is none.
  assign in_ready = ~out_valid | out_ready;

  // Next-state logic without a skid entry; FULL is never reached.
  always_comb begin
    state_nxt    = state;
    load_main_in = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else if (in_xfer) begin
      state_nxt    = BUSY;
      load_main_in = 1'b1;
    end else if (out_ready) begin
      state_nxt = EMPTY;
    end
  end

  // Main register loads only from the input; otherwise it holds
  always_comb begin
    data_nxt = main_data;
    if (load_main_in) begin
      data_nxt = in_data;
    end
  end

  // Control mirrors the data path, with a bubble whenever empty
  always_comb begin
    ctrl_nxt = main_ctrl;
    if (state_nxt == EMPTY) begin
      ctrl_nxt = CTRL_BUBBLE;
    end else if (load_main_in) begin
      ctrl_nxt = in_ctrl;
    end
  end

`endif

  // State and main register; out_valid is a flop copy of occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      main_ctrl <= CTRL_BUBBLE;
      main_data <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      main_ctrl <= ctrl_nxt;
      main_data <= data_nxt;
    end
  end

  // Back-pressure counter, flush cycles included
  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (out_valid & ~out_ready),
    .count(stall_cnt)
  );

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline register; next generation of the fixed inter-stage latch blocks.
- Carries a control bundle and a data payload between stages.
- Adds valid/ready handshake, back-pressure (stall), synchronous flush with bubble insertion, and a stall-cycle counter.
- Instanced at every stage boundary: IF/ID, ID/EX, EX/MEM, MEM/WB.

Parameters:
- CTRL_W, 10: width of the control bundle (RWrite, WBsrc, MWrite, ALUop, ...).
- DATA_W, 123: width of the payload (operands, funct, dst reg, immediate).
- CTRL_BUBBLE, 0: value driven on out_ctrl whenever out_valid=0; a bubble must never write regfile or memory.
- CNT_W, 16: width of stall_cnt.

Ports:
- clk, in, 1: clock; all state updates on posedge.
- rst, in, 1: asynchronous, active-high reset.
- flush, in, 1: synchronous kill of stage contents.
- in_valid, in, 1: upstream holds a valid item.
- in_ready, out, 1: stage can accept; registered when PIPE_SKID_EN is defined.
- in_ctrl, in, CTRL_W: upstream control bundle.
- in_data, in, DATA_W: upstream payload.
- out_valid, out, 1: out_ctrl/out_data hold a valid item.
- out_ready, in, 1: downstream accepts this cycle.
- out_ctrl, out, CTRL_W: registered control; equals CTRL_BUBBLE when out_valid=0.
- out_data, out, DATA_W: registered payload.
- stall_cnt, out, CNT_W: saturating count of back-pressured cycles.

Behaviour:
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready. All are sampled at posedge clk.
- Reset (async, immediate): state EMPTY, out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, skid regs=0, in_ready=1, stall_cnt=0.
- Latency: an accepted item appears on out_* the cycle after acceptance. Throughput is 1 item/cycle when out_ready=1.
- Ordering: items leave in acceptance order. No duplication; no loss except by flush.
- Main register + skid register with states EMPTY, BUSY (main full), FULL (main+skid full). in_ready = (state != FULL).
  - EMPTY: in_valid -> BUSY, main<=in.
  - BUSY, input transfer and output transfer -> BUSY, main<=in.
  - BUSY, input transfer without output transfer -> FULL, skid<=in.
  - BUSY, output transfer only -> EMPTY.
  - BUSY, neither -> hold.
  - FULL: out_ready -> BUSY, main<=skid. No input accepted while FULL.
- Hold: while stalled, out_ctrl/out_data stay stable and out_valid stays 1.
- Flush (priority over every other event): next state EMPTY, out_valid=0, out_ctrl=CTRL_BUBBLE. Main and skid contents are discarded.
  - An input transfer in the flush cycle is consumed and discarded.
  - An output transfer in the flush cycle completes normally.
  - in_ready=1 the cycle after.
- out_data is don't-care when out_valid=0; the implementation holds the last value.
- stall_cnt: +1 on every cycle with out_valid & !out_ready, also in a flush cycle. Saturates at 2^CNT_W-1. Cleared only by rst.
- Reset asserted mid-operation: all in-flight items are dropped without handshake.

Optional Feature:
- Macro: PIPE_SKID_EN.
- Defined: two-entry skid as above; in_ready is a flop output, so there is no combinational in->out ready path.
- Undefined: main register only, no FULL state. in_ready = !out_valid | out_ready (combinational). Same latency, throughput and flush semantics.

Decomposition:
- Shared package pipe_pkg:
  - state enum {EMPTY, BUSY, FULL}.
  - Per-stage CTRL_W/DATA_W constants.
  - Per-stage CTRL_BUBBLE constants.
- Sub-module: pipe_sat_cnt (CNT_W-bit saturating counter with enable and async reset), reused by the perf counters.

Test Plan:
- Reset, then stream 0x1..0x8 with in_valid=1 and out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, each 1 cycle after acceptance; stall_cnt=0.
- Accept 0xA, 0xB with out_ready=0 -> FULL, in_ready=0, out_data=0xA held. Raise out_ready -> 0xA then 0xB, no loss; stall_cnt equals the held cycles.
- FULL state plus flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, in_ready=1. Neither held item nor the input item ever appears.
- CNT_W=3, out_ready=0 with a valid item for 10 cycles -> stall_cnt=7, no wrap.
- Assert rst mid-stream, asynchronously between edges -> out_valid=0 and out_ctrl=CTRL_BUBBLE immediately. After release, the first new item passes with 1-cycle latency.
- Build without PIPE_SKID_EN, out_valid=1, toggle out_ready -> in_ready follows out_ready in the same cycle, and the data sequence matches the skid build.
